// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: shares the flash read port between fetch/data requesters and slots config writes into idle gaps; FLASH_ARB_FAIRNESS_EN bounds data starvation
module flash_port_arbiter #(parameter logic [3:0] STARVE_LIMIT = 4'd8) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [23:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [23:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [3:0]  c_we,
  input  logic [31:0] c_di,
  output logic        c_ready,
  output logic [31:0] c_do,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_addr,
  input  logic [31:0] m_rdata,
  output logic [3:0]  m_cfgreg_we,
  output logic [31:0] m_cfgreg_di,
  input  logic [31:0] m_cfgreg_do,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, CFG} state_t;
  state_t state, state_nx;
  logic pick_d, i_done, d_done;
  assign i_done = state == GNT_I && m_ready;
  assign d_done = state == GNT_D && m_ready;
`ifdef FLASH_ARB_FAIRNESS_EN
  logic [3:0] starve;
  assign pick_d = d_valid && (!i_valid || starve >= STARVE_LIMIT);
  always_ff @(posedge clk)
    if (!resetn) starve <= '0;
    else if (d_done) starve <= '0;
    else if (i_done && d_valid && starve != 4'hf) starve <= starve + 4'd1;
`else
  logic last_d;
  assign pick_d = d_valid && (!i_valid || !last_d);
  always_ff @(posedge clk)
    if (!resetn) last_d <= 1'b1;
    else if (i_done || d_done) last_d <= d_done;
`endif
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = |c_we ? CFG : pick_d ? GNT_D : i_valid ? GNT_I : IDLE;
    else if (state == GNT_I) state_nx = m_ready || !i_valid ? IDLE : GNT_I;
    else if (state == GNT_D) state_nx = m_ready || !d_valid ? IDLE : GNT_D;
  end
  assign m_valid = (state == GNT_I && i_valid) || (state == GNT_D && d_valid);
  assign m_addr = (state == GNT_D ? d_addr : i_addr) & 24'hfffffc;
  assign i_ready = i_done;
  assign d_ready = d_done;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign c_ready = state == CFG;
  assign m_cfgreg_we = c_ready ? c_we : 4'd0;
  assign m_cfgreg_di = c_ready ? c_di : 32'd0;
  assign c_do = m_cfgreg_do;
  assign busy = state == GNT_I || state == GNT_D;
endmodule
